nn_result_ctrl: RTL and testbench
=================================

// Module: nn_result_ctrl
// PURPOSE
//  Parametrised controller between the button/sync front end and the neural_network core.
//  Launches a compute on a button pulse and waits for the core's done handshake, with timeout.
//  Snapshots the class probabilities and runs a sequential argmax scan.
//  Drives the value to show on the hex displays plus a one-hot winner LED vector.
// PARAMETERS
//  N_CLASSES   10          number of output classes (>=2)
//  PROB_W      16          width of one probability word, unsigned
//  SEL_W       $clog2(N_CLASSES)  class index width (derived, do not override)
//  TIMEOUT     1048576     max cycles waited for nn_done before abort
//  CYCLE_TICKS 50000000    auto-cycle dwell in cycles (used only with NN_AUTO_CYCLE_EN)
// PORTS
//  Clk          in   1                 system clock, all state on rising edge
//  Reset_n      in   1                 asynchronous active-low reset
//  compute_req  in   1                 one-cycle pulse from button synchroniser
//  sel          in   SEL_W             class to display (manual mode)
//  prob         in   N_CLASSES*PROB_W  class i at [i*PROB_W +: PROB_W]
//  nn_done      in   1                 core result valid, sampled in WAIT only
//  nn_start     out  1                 one-cycle compute launch to core
//  busy         out  1                 high whenever state != IDLE
//  best_class   out  SEL_W             argmax index of last completed run
//  best_prob    out  PROB_W            probability of best_class
//  display      out  PROB_W            registered value for hex driver
//  class_led    out  N_CLASSES         one-hot of best_class, 0 until first result
//  timeout_err  out  1                 sticky: last run aborted by timeout
// BEHAVIOUR
//  - Reset_n low: all outputs 0, snapshot regs 0, state IDLE, counters 0; effective mid-run, no partial commit.
//  - FSM IDLE->START->WAIT->SCAN->IDLE.
//  - IDLE: compute_req -> START, clears timeout_err. compute_req in any other state is ignored, not queued.
//  - START: nn_start=1 for exactly this cycle -> WAIT; wait counter cleared.
//  - WAIT: nn_done=1 -> copy prob into snapshot[0..N-1], -> SCAN, idx=0.
//    Otherwise counter++; at count TIMEOUT-1 without done: timeout_err=1, -> IDLE, outputs keep old result.
//    nn_done and timeout on the same cycle: done wins.
//  - SCAN: one class per cycle, idx 0..N_CLASSES-1; running max starts at snapshot[0].
//    Replace only on strictly greater (unsigned), so ties resolve to the lowest index.
//    On the idx=N_CLASSES-1 cycle, next edge commits best_class, best_prob, class_led -> IDLE.
//    Latency: nn_done edge to committed outputs = N_CLASSES+1 cycles.
//  - nn_done outside WAIT is ignored; snapshot is never updated outside the WAIT->SCAN edge.
//  - display: registered snapshot[disp_idx], 1-cycle latency; disp_idx >= N_CLASSES -> display=0.
//  - Manual mode: disp_idx = sel. Snapshot is stable during SCAN, so display is valid while busy.
// CONFIGURATION
//  NN_AUTO_CYCLE_EN defined: sel ignored; disp_idx advances every CYCLE_TICKS cycles.
//    Wraps N_CLASSES-1 -> 0; at each commit disp_idx = new best_class and dwell counter = 0.
//  NN_AUTO_CYCLE_EN undefined: dwell counter and logic absent; disp_idx = sel.
// TESTING
//  1 reset: Reset_n=0 -> all outputs 0, busy=0, class_led=0.
//  2 launch: compute_req pulse -> nn_start=1 next cycle only.
//    prob={9:100, 3:900, rest 50}; nn_done after 20 cycles -> after 11 more cycles best_class=3, best_prob=900, class_led=10'h008.
//  3 tie: classes 2 and 7 both 0xFFFF, rest 0 -> best_class=2. sel=7 -> display=0xFFFF one cycle later.
//  4 timeout: TIMEOUT=64, no nn_done -> timeout_err=1 at cycle 64 after START, busy=0, prior result kept.
//    Next compute_req clears timeout_err.
//  5 abuse: compute_req during WAIT ignored; nn_done in IDLE ignored; Reset_n low mid-SCAN -> IDLE, outputs 0.
//  6 NN_AUTO_CYCLE_EN, CYCLE_TICKS=4, N_CLASSES=10: after commit best=9, display shows class 9,0,1 each for 4 cycles.

Source files
------------

// File: rtl/nn_result_ctrl.sv
// Result controller for the neural_network core: launch on request, wait for done with a
// timeout, snapshot the probabilities, scan for the argmax. Optional macro: NN_AUTO_CYCLE_EN.
module nn_result_ctrl #(
   parameter int unsigned N_CLASSES   = 10,
   parameter int unsigned PROB_W      = 16,
   parameter int unsigned TIMEOUT     = 1048576,
   parameter int unsigned CYCLE_TICKS = 50000000,
   localparam int unsigned SEL_W      = $clog2(N_CLASSES)
) (
   input  logic                        Clk,
   input  logic                        Reset_n,
   input  logic                        compute_req,
   input  logic [SEL_W-1:0]            sel,
   input  logic [N_CLASSES*PROB_W-1:0] prob,
   input  logic                        nn_done,
   output logic                        nn_start,
   output logic                        busy,
   output logic [SEL_W-1:0]            best_class,
   output logic [PROB_W-1:0]           best_prob,
   output logic [PROB_W-1:0]           display,
   output logic [N_CLASSES-1:0]        class_led,
   output logic                        timeout_err
);

   localparam int unsigned      CntW    = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT - 1);
   localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N_CLASSES - 1);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StScan} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q;
   logic [SEL_W-1:0]    idx_q, max_idx_q, best_class_q;
   logic [PROB_W-1:0]   max_q, best_prob_q, display_q;
   logic [PROB_W-1:0]   snap_q [N_CLASSES];
   logic [N_CLASSES-1:0] class_led_q;
   logic                timeout_err_q;

   logic                timeout_hit, commit;
   logic [PROB_W-1:0]   cur_val, cand_val;
   logic [SEL_W-1:0]    cand_idx, disp_idx;
   logic [N_CLASSES-1:0] led_d;

   assign timeout_hit = (cnt_q == CntLast);
   assign commit      = (state_q == StScan) && (idx_q == LastIdx);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (compute_req) state_d = StStart;
         StStart: state_d = StWait;
         StWait: begin
            if (nn_done)          state_d = StScan;
            else if (timeout_hit) state_d = StIdle;
         end
         StScan:  if (idx_q == LastIdx) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      nn_start = (state_q == StStart);
      busy     = (state_q != StIdle);
   end

   // Index 0 seeds the running max; later entries replace it only when strictly greater.
   always_comb begin
      cur_val  = snap_q[idx_q];
      cand_val = max_q;
      cand_idx = max_idx_q;
      if ((idx_q == '0) || (cur_val > max_q)) begin
         cand_val = cur_val;
         cand_idx = idx_q;
      end
      led_d           = '0;
      led_d[cand_idx] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         max_q         <= '0;
         max_idx_q     <= '0;
         best_class_q  <= '0;
         best_prob_q   <= '0;
         class_led_q   <= '0;
         timeout_err_q <= 1'b0;
         display_q     <= '0;
         for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= '0;
      end else begin
         case (state_q)
            StIdle:  if (compute_req) timeout_err_q <= 1'b0;
            StStart: cnt_q <= '0;
            StWait: begin
               if (nn_done) begin
                  for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= prob[i*PROB_W +: PROB_W];
                  idx_q <= '0;
               end else if (timeout_hit) begin
                  timeout_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StScan: begin
               max_q     <= cand_val;
               max_idx_q <= cand_idx;
               if (idx_q == LastIdx) begin
                  idx_q        <= '0;
                  best_class_q <= cand_idx;
                  best_prob_q  <= cand_val;
                  class_led_q  <= led_d;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
         display_q <= (disp_idx <= LastIdx) ? snap_q[disp_idx] : '0;
      end
   end

`ifdef NN_AUTO_CYCLE_EN
   localparam int unsigned        DwellW    = $clog2(CYCLE_TICKS + 1);
   localparam logic [DwellW-1:0]  DwellLast = DwellW'(CYCLE_TICKS - 1);

   logic [DwellW-1:0] dwell_q;
   logic [SEL_W-1:0]  disp_idx_q;
   logic              unused_sel;

   assign unused_sel = ^sel;

   // A fresh result restarts the rotation on the winning class.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         dwell_q    <= '0;
         disp_idx_q <= '0;
      end else if (commit) begin
         dwell_q    <= '0;
         disp_idx_q <= cand_idx;
      end else if (dwell_q == DwellLast) begin
         dwell_q    <= '0;
         disp_idx_q <= (disp_idx_q == LastIdx) ? '0 : disp_idx_q + 1'b1;
      end else begin
         dwell_q <= dwell_q + 1'b1;
      end
   end

   assign disp_idx = disp_idx_q;
`else
   logic unused_commit;
   assign unused_commit = commit;
   assign disp_idx      = sel;
`endif

   assign best_class  = best_class_q;
   assign best_prob   = best_prob_q;
   assign class_led   = class_led_q;
   assign display     = display_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_nn_result_ctrl.sv
// Scoreboard bench for nn_result_ctrl: expected argmax results are queued when nn_done is
// driven and compared at commit. Define NN_AUTO_CYCLE_EN to exercise the rotating display.
module tb_nn_result_ctrl;

   localparam int unsigned NC = 10;
   localparam int unsigned PW = 16;
   localparam int unsigned SW = 4;
   localparam int unsigned TO = 64;

   typedef logic [NC*PW-1:0] pvec_t;
   typedef struct {
      int cls;
      int val;
   } exp_t;

   logic          Clk, Reset_n, compute_req, nn_done;
   logic          nn_start, busy, timeout_err;
   logic [SW-1:0] sel, best_class;
   pvec_t         prob;
   logic [PW-1:0] best_prob, display;
   logic [NC-1:0] class_led;

   int    checks = 0;
   int    errors = 0;
   exp_t  sb[$];
   exp_t  last_exp;
   pvec_t last_pv;

   nn_result_ctrl #(
      .N_CLASSES  (NC),
      .PROB_W     (PW),
      .TIMEOUT    (TO),
      .CYCLE_TICKS(4)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .compute_req(compute_req),
      .sel        (sel),
      .prob       (prob),
      .nn_done    (nn_done),
      .nn_start   (nn_start),
      .busy       (busy),
      .best_class (best_class),
      .best_prob  (best_prob),
      .display    (display),
      .class_led  (class_led),
      .timeout_err(timeout_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic exp_t model(input pvec_t pv);
      exp_t e;
      e.cls = 0;
      e.val = int'(pv[0 +: PW]);
      for (int i = 1; i < NC; i++) begin
         if (int'(pv[i*PW +: PW]) > e.val) begin
            e.cls = i;
            e.val = int'(pv[i*PW +: PW]);
         end
      end
      return e;
   endfunction

   function automatic logic [SW+PW+NC-1:0] pack_exp(input exp_t e);
      logic [NC-1:0] l;
      l        = '0;
      l[e.cls] = 1'b1;
      return {SW'(e.cls), PW'(e.val), l};
   endfunction

   // Drive nn_done with pv (state must be WAIT) and wait, bounded, for the commit.
   task automatic finish_run(input pvec_t pv);
      prob    = pv;
      nn_done = 1'b1;
      sb.push_back(model(pv));
      last_pv = pv;
      tick();
      nn_done = 1'b0;
      for (int i = 0; i < 3 * NC && busy; i++) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL run_done: busy=%b required 0 after bound", busy);
      end
   endtask

   task automatic run_one(input pvec_t pv, input int delay);
      compute_req = 1'b1;
      tick();
      compute_req = 1'b0;
      repeat (delay) tick();
      finish_run(pv);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; compute_req = 1'b0; nn_done = 1'b0; sel = '0; prob = '0;
      repeat (3) tick();
      checks++;
      if ({nn_start, busy, best_class, best_prob, display, class_led, timeout_err} !== '0) begin
         errors++;
         $display("FAIL reset: outputs=%h required 0",
                  {nn_start, busy, best_class, best_prob, display, class_led, timeout_err});
      end
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_launch();
      pvec_t pv;
      exp_t  e;
      for (int i = 0; i < NC; i++) pv[i*PW +: PW] = 16'd50;
      pv[9*PW +: PW] = 16'd100;
      pv[3*PW +: PW] = 16'd900;
      compute_req = 1'b1;
      tick();
      compute_req = 1'b0;
      checks++;
      if (nn_start !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL launch_start: nn_start=%b busy=%b required 1 1", nn_start, busy);
      end
      tick();
      checks++;
      if (nn_start !== 1'b0) begin
         errors++;
         $display("FAIL launch_pulse: nn_start=%b required 0", nn_start);
      end
      repeat (19) tick();
      prob    = pv;
      nn_done = 1'b1;
      sb.push_back(model(pv));
      last_pv = pv;
      tick();
      nn_done = 1'b0;
      repeat (9) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL launch_latency: busy=%b required 1 before commit", busy);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if ({best_class, best_prob, class_led} !== pack_exp(e) || e.cls != 3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL launch_result: got %h busy=%b required %h (class 3, 900)",
                  {best_class, best_prob, class_led}, busy, pack_exp(e));
      end
      last_exp = e;
   endtask

   task automatic test_tie();
      pvec_t pv;
      exp_t  e;
      pv = '0;
      pv[2*PW +: PW] = 16'hFFFF;
      pv[7*PW +: PW] = 16'hFFFF;
      run_one(pv, 3);
      e = sb.pop_front();
      checks++;
      if ({best_class, best_prob, class_led} !== pack_exp(e) || best_class !== 4'd2) begin
         errors++;
         $display("FAIL tie_result: got %h required %h", {best_class, best_prob, class_led},
                  pack_exp(e));
      end
      last_exp = e;
`ifndef NN_AUTO_CYCLE_EN
      sel = 4'd7;
      tick();
      checks++;
      if (display !== 16'hFFFF) begin
         errors++;
         $display("FAIL tie_display7: display=%h required ffff", display);
      end
      sel = 4'd5;
      tick();
      checks++;
      if (display !== 16'h0000) begin
         errors++;
         $display("FAIL tie_display5: display=%h required 0000", display);
      end
      for (int s = 10; s < 16; s += 5) begin
         sel = 4'(s);
         tick();
         checks++;
         if (display !== '0) begin
            errors++;
            $display("FAIL display_range sel=%0d: display=%h required 0", s, display);
         end
      end
`endif
   endtask

   task automatic test_timeout();
      pvec_t pv;
      exp_t  e;
      compute_req = 1'b1;
      tick();
      compute_req = 1'b0;
      repeat (TO) tick();
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: timeout_err=%b busy=%b required 0 1", timeout_err, busy);
      end
      tick();
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire: timeout_err=%b busy=%b required 1 0", timeout_err, busy);
      end
      checks++;
      if ({best_class, best_prob, class_led} !== pack_exp(last_exp)) begin
         errors++;
         $display("FAIL timeout_keep: got %h required %h", {best_class, best_prob, class_led},
                  pack_exp(last_exp));
      end
      compute_req = 1'b1;
      tick();
      compute_req = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: timeout_err=%b required 0", timeout_err);
      end
      tick();
      for (int i = 0; i < NC; i++) pv[i*PW +: PW] = PW'(i * 7);
      finish_run(pv);
      e = sb.pop_front();
      checks++;
      if ({best_class, best_prob, class_led} !== pack_exp(e)) begin
         errors++;
         $display("FAIL timeout_rerun: got %h required %h", {best_class, best_prob, class_led},
                  pack_exp(e));
      end
      last_exp = e;
   endtask

   task automatic test_abuse();
      pvec_t pv;
      exp_t  e;
      logic  extra;
      // nn_done while idle must not touch the snapshot or results
      prob    = {NC{16'h1234}};
      nn_done = 1'b1;
      tick();
      nn_done = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || {best_class, best_prob, class_led} !== pack_exp(last_exp)) begin
         errors++;
         $display("FAIL idle_done: busy=%b got %h required 0 %h", busy,
                  {best_class, best_prob, class_led}, pack_exp(last_exp));
      end
`ifndef NN_AUTO_CYCLE_EN
      sel = 4'd9;
      tick();
      checks++;
      if (display !== last_pv[9*PW +: PW]) begin
         errors++;
         $display("FAIL idle_done_snapshot: display=%h required %h", display, last_pv[9*PW +: PW]);
      end
`endif
      // compute_req during WAIT is dropped, not queued
      for (int i = 0; i < NC; i++) pv[i*PW +: PW] = PW'(1000 - i * 13);
      compute_req = 1'b1;
      tick();
      compute_req = 1'b0;
      repeat (2) tick();
      compute_req = 1'b1;
      tick();
      compute_req = 1'b0;
      finish_run(pv);
      e = sb.pop_front();
      checks++;
      if ({best_class, best_prob, class_led} !== pack_exp(e)) begin
         errors++;
         $display("FAIL wait_req_result: got %h required %h", {best_class, best_prob, class_led},
                  pack_exp(e));
      end
      last_exp = e;
      extra = 1'b0;
      repeat (4) begin
         tick();
         extra = extra | busy | nn_start;
      end
      checks++;
      if (extra !== 1'b0) begin
         errors++;
         $display("FAIL wait_req_queued: busy|nn_start=%b required 0", extra);
      end
      // reset in the middle of a scan: nothing committed
      compute_req = 1'b1;
      tick();
      compute_req = 1'b0;
      tick();
      prob    = {NC{16'h4444}};
      nn_done = 1'b1;
      tick();
      nn_done = 1'b0;
      repeat (4) tick();
      Reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, best_class, best_prob, display, class_led, timeout_err} !== '0) begin
         errors++;
         $display("FAIL scan_reset: outputs=%h required 0",
                  {busy, best_class, best_prob, display, class_led, timeout_err});
      end
      tick();
      Reset_n = 1'b1;
      repeat (NC + 2) tick();
      checks++;
      if ({busy, best_class, best_prob, class_led} !== '0) begin
         errors++;
         $display("FAIL scan_reset_commit: outputs=%h required 0",
                  {busy, best_class, best_prob, class_led});
      end
   endtask

   task automatic test_back_to_back();
      pvec_t pv;
      exp_t  e;
      int    s;
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < NC; i++)
            pv[i*PW +: PW] = (r < 2) ? PW'($urandom_range(0, 7)) : PW'($urandom);
         if (r == 4) pv[(NC-1)*PW +: PW] = 16'hFFFF;
         run_one(pv, int'($urandom_range(1, 10)));
         e = sb.pop_front();
         checks++;
         if ({best_class, best_prob, class_led} !== pack_exp(e)) begin
            errors++;
            $display("FAIL b2b_result run=%0d: got %h required %h", r,
                     {best_class, best_prob, class_led}, pack_exp(e));
         end
`ifndef NN_AUTO_CYCLE_EN
         s   = int'($urandom_range(0, NC - 1));
         sel = 4'(s);
         tick();
         checks++;
         if (display !== pv[s*PW +: PW]) begin
            errors++;
            $display("FAIL b2b_display run=%0d sel=%0d: display=%h required %h", r, s, display,
                     pv[s*PW +: PW]);
         end
`endif
      end
   endtask

`ifdef NN_AUTO_CYCLE_EN
   task automatic test_auto_cycle();
      pvec_t pv;
      exp_t  e;
      int    ex;
      for (int i = 0; i < NC; i++) pv[i*PW +: PW] = PW'(i * 10 + 1);
      pv[9*PW +: PW] = 16'd1000;
      run_one(pv, 2);
      e = sb.pop_front();
      checks++;
      if ({best_class, best_prob, class_led} !== pack_exp(e)) begin
         errors++;
         $display("FAIL auto_result: got %h required %h", {best_class, best_prob, class_led},
                  pack_exp(e));
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         ex = (k < 4) ? 9 : (k < 8) ? 0 : 1;
         checks++;
         if (display !== pv[ex*PW +: PW]) begin
            errors++;
            $display("FAIL auto_display cycle=%0d: display=%h required %h (class %0d)", k, display,
                     pv[ex*PW +: PW], ex);
         end
      end
   endtask
`endif

   initial begin
      Reset_n = 1'b0;
      test_reset();
      test_launch();
      test_tie();
      test_timeout();
      test_abuse();
      test_back_to_back();
`ifdef NN_AUTO_CYCLE_EN
      test_auto_cycle();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
